// File: rtl/gpregs_wb_arbiter_if.sv
// Write-back request bundle: the ALU and LSU sources that compete for the single
// GPREGS write port, plus the arbiter's per-source ready.
interface gpregs_wb_arbiter_if #(
  parameter int REG_DATA_WIDTH = 32
);
  logic                      alu_valid;
  logic                      alu_ready;
  logic [4:0]                alu_rd;
  logic [REG_DATA_WIDTH-1:0] alu_data;
  logic                      lsu_valid;
  logic                      lsu_ready;
  logic [4:0]                lsu_rd;
  logic [REG_DATA_WIDTH-1:0] lsu_data;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready
  );
endinterface

// File: rtl/gpregs_wb_arbiter.sv
// Round-robin write-back arbiter for the GPREGS write port with a per-register
// pending-write scoreboard used by decode for RAW hazard detection.
module gpregs_wb_arbiter #(
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  gpregs_wb_arbiter_if.slave        wb,
  output logic [4:0]                write_reg,
  output logic [REG_DATA_WIDTH-1:0] din,
  output logic                      din_enable,
  input  logic                      issue_valid,
  input  logic [4:0]                issue_rd,
  input  logic [4:0]                chk_reg_0,
  input  logic [4:0]                chk_reg_1,
  output logic                      chk_busy_0,
  output logic                      chk_busy_1,
  output logic [31:0]               wb_count
);

  logic                      grant_alu;
  logic                      grant_lsu;
  logic                      last_lsu_q, last_lsu_d;
  logic [4:0]                write_reg_q, write_reg_d;
  logic [REG_DATA_WIDTH-1:0] din_q, din_d;
  logic                      din_enable_q, din_enable_d;
  logic [31:0]               busy_q, busy_d;
  logic [31:0]               wb_count_q, wb_count_d;

  // On a tie the source that did not win last time takes the port.
  always_comb begin
    grant_alu = !reset && wb.alu_valid && (!wb.lsu_valid || last_lsu_q);
    grant_lsu = !reset && wb.lsu_valid && (!wb.alu_valid || !last_lsu_q);
  end

  assign wb.alu_ready = grant_alu;
  assign wb.lsu_ready = grant_lsu;

  always_comb begin
    last_lsu_d   = last_lsu_q;
    write_reg_d  = write_reg_q;
    din_d        = din_q;
    din_enable_d = 1'b0;
    busy_d       = busy_q;
    wb_count_d   = wb_count_q + {31'd0, din_enable_q};

    if (grant_alu) begin
      last_lsu_d   = 1'b0;
      write_reg_d  = wb.alu_rd;
      din_d        = wb.alu_data;
      din_enable_d = (wb.alu_rd != 5'd0);
    end else if (grant_lsu) begin
      last_lsu_d   = 1'b1;
      write_reg_d  = wb.lsu_rd;
      din_d        = wb.lsu_data;
      din_enable_d = (wb.lsu_rd != 5'd0);
    end

    // Clear before set so a newer producer issued on the commit edge stays pending.
    if (din_enable_q) begin
      busy_d[write_reg_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_lsu_q   <= 1'b1;
      write_reg_q  <= 5'd0;
      din_q        <= '0;
      din_enable_q <= 1'b0;
      busy_q       <= 32'd0;
      wb_count_q   <= 32'd0;
    end else begin
      last_lsu_q   <= last_lsu_d;
      write_reg_q  <= write_reg_d;
      din_q        <= din_d;
      din_enable_q <= din_enable_d;
      busy_q       <= busy_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign write_reg  = write_reg_q;
  assign din        = din_q;
  assign din_enable = din_enable_q;
  assign wb_count   = wb_count_q;
  assign chk_busy_0 = busy_q[chk_reg_0];
  assign chk_busy_1 = busy_q[chk_reg_1];

endmodule

// File: tb/tb_gpregs_wb_arbiter.sv
// Directed bench for gpregs_wb_arbiter: a transaction-level model predicts every
// output each cycle, and hand-computed literals pin both the model and the DUT.
module tb_gpregs_wb_arbiter;
  localparam int W    = 32;
  localparam int NONE = 0;
  localparam int ALU  = 1;
  localparam int LSU  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    write_reg;
  logic [W-1:0]  din;
  logic          din_enable;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic [4:0]    chk_reg_0, chk_reg_1;
  logic          chk_busy_0, chk_busy_1;
  logic [31:0]   wb_count;

  gpregs_wb_arbiter_if #(.REG_DATA_WIDTH(W)) wbif ();

  gpregs_wb_arbiter #(.REG_DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .wb(wbif.slave),
    .write_reg(write_reg), .din(din), .din_enable(din_enable),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_reg_0(chk_reg_0), .chk_reg_1(chk_reg_1),
    .chk_busy_0(chk_busy_0), .chk_busy_1(chk_busy_1),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit compare_on = 1'b0;

  // Model state: what the GPREGS write port and scoreboard must look like.
  int          m_last;
  logic [4:0]  m_wr;
  logic [W-1:0] m_din;
  bit          m_en;
  int unsigned m_count;
  bit          m_busy [32];
  logic [W-1:0] m_rf  [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int who_wins();
    if (reset) return NONE;
    if (wbif.alu_valid && wbif.lsu_valid) return (m_last == LSU) ? ALU : LSU;
    if (wbif.alu_valid) return ALU;
    if (wbif.lsu_valid) return LSU;
    return NONE;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
  end

  always @(posedge clk) begin
    int g;
    g = who_wins();
    if (reset) begin
      m_last  <= LSU;
      m_wr    <= 5'd0;
      m_din   <= '0;
      m_en    <= 1'b0;
      m_count <= 0;
      for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
    end else begin
      if (m_en) begin
        m_rf[m_wr]  <= m_din;
        m_count     <= m_count + 1;
        if (!(issue_valid && issue_rd == m_wr)) m_busy[m_wr] <= 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] <= 1'b1;
      if (g == ALU) begin
        m_last <= ALU; m_wr <= wbif.alu_rd; m_din <= wbif.alu_data; m_en <= (wbif.alu_rd != 0);
      end else if (g == LSU) begin
        m_last <= LSU; m_wr <= wbif.lsu_rd; m_din <= wbif.lsu_data; m_en <= (wbif.lsu_rd != 0);
      end else begin
        m_en <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (compare_on) begin
      int g;
      g = who_wins();
      chk("alu_ready",  wbif.alu_ready, (g == ALU));
      chk("lsu_ready",  wbif.lsu_ready, (g == LSU));
      chk("din_enable", din_enable, m_en);
      chk("write_reg",  write_reg, m_wr);
      chk("din",        din, m_din);
      chk("wb_count",   wb_count, m_count);
      chk("chk_busy_0", chk_busy_0, (chk_reg_0 == 0) ? 1'b0 : m_busy[chk_reg_0]);
      chk("chk_busy_1", chk_busy_1, (chk_reg_1 == 0) ? 1'b0 : m_busy[chk_reg_1]);
    end
  end

  task automatic set(input bit av, input logic [4:0] ard, input logic [W-1:0] ad,
                     input bit lv, input logic [4:0] lrd, input logic [W-1:0] ld,
                     input bit iv, input logic [4:0] ird);
    wbif.alu_valid = av; wbif.alu_rd = ard; wbif.alu_data = ad;
    wbif.lsu_valid = lv; wbif.lsu_rd = lrd; wbif.lsu_data = ld;
    issue_valid = iv; issue_rd = ird;
  endtask

  task automatic to_negedge();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set(0, 5'd0, '0, 0, 5'd0, '0, 0, 5'd0);
  endtask

  initial begin
    reset = 1'b1; chk_reg_0 = 5'd5; chk_reg_1 = 5'd0;
    set(1, 5'd7, 32'h77, 1, 5'd9, 32'h99, 0, 5'd0);
    next_cycle();                       // C1: still in reset
    compare_on = 1'b1;
    to_negedge();
    chk("rst_alu_ready", wbif.alu_ready, 1'b0);
    chk("rst_lsu_ready", wbif.lsu_ready, 1'b0);
    chk("rst_din_enable", din_enable, 1'b0);
    chk("rst_wb_count", wb_count, 32'd0);
    next_cycle();                       // C2: release, both valid
    reset = 1'b0;
    to_negedge();
    chk("first_tie_alu", wbif.alu_ready, 1'b1);
    chk("first_tie_lsu", wbif.lsu_ready, 1'b0);
    next_cycle();                       // C3
    idle();
    to_negedge();
    chk("x7_write_reg", write_reg, 5'd7);
    next_cycle();                       // C4: single ALU write x1
    set(1, 5'd1, 32'h12, 0, 5'd0, '0, 0, 5'd0);
    next_cycle();                       // C5
    idle();
    to_negedge();
    chk("single_write_reg", write_reg, 5'd1);
    chk("single_din", din, 32'h12);
    chk("single_din_enable", din_enable, 1'b1);
    chk("single_count", wb_count, 32'd1);
    next_cycle();                       // C6: LSU x0 write
    set(0, 5'd0, '0, 1, 5'd0, 32'hFF, 0, 5'd0);
    to_negedge();
    chk("model_rf_x1", m_rf[1], 32'h12);
    chk("x0_lsu_ready", wbif.lsu_ready, 1'b1);
    chk("count_2", wb_count, 32'd2);
    next_cycle();                       // C7
    idle();
    to_negedge();
    chk("x0_din_enable", din_enable, 1'b0);
    next_cycle();                       // C8..C11: contention
    for (int i = 0; i < 4; i++) begin
      set(1, 5'd2, 32'h11, 1, 5'd3, 32'h22, 0, 5'd0);
      to_negedge();
      chk("rr_alu_ready", wbif.alu_ready, (i % 2 == 0));
      chk("rr_lsu_ready", wbif.lsu_ready, (i % 2 == 1));
      if (i > 0) chk("rr_din_enable", din_enable, 1'b1);
      next_cycle();
    end
    idle();                             // C12
    to_negedge();
    chk("rr_last_din_enable", din_enable, 1'b1);
    chk("rr_last_write_reg", write_reg, 5'd3);
    chk("model_rf_x0", m_rf[0], 32'h0);
    next_cycle();                       // C13: issue x5
    set(0, 5'd0, '0, 0, 5'd0, '0, 1, 5'd5);
    to_negedge();
    chk("rr_count", wb_count, 32'd6);
    chk("model_rf_x2", m_rf[2], 32'h11);
    chk("model_rf_x3", m_rf[3], 32'h22);
    chk("no_bypass", chk_busy_0, 1'b0);
    next_cycle();                       // C14: ALU writes x5
    set(1, 5'd5, 32'h55, 0, 5'd0, '0, 0, 5'd0);
    to_negedge();
    chk("sb_busy_set", chk_busy_0, 1'b1);
    next_cycle();                       // C15
    idle();
    to_negedge();
    chk("sb_busy_during_we", chk_busy_0, 1'b1);
    chk("sb_we", din_enable, 1'b1);
    next_cycle();                       // C16: issue x5 plus write x5
    set(1, 5'd5, 32'h56, 0, 5'd0, '0, 1, 5'd5);
    to_negedge();
    chk("sb_busy_cleared", chk_busy_0, 1'b0);
    next_cycle();                       // C17: reissue on commit edge
    set(0, 5'd0, '0, 0, 5'd0, '0, 1, 5'd5);
    to_negedge();
    chk("coll_we", din_enable, 1'b1);
    next_cycle();                       // C18: issue x0
    set(0, 5'd0, '0, 0, 5'd0, '0, 1, 5'd0);
    to_negedge();
    chk("coll_set_wins", chk_busy_0, 1'b1);
    next_cycle();                       // C19: reset with a pending request
    set(1, 5'd4, 32'h44, 0, 5'd0, '0, 0, 5'd0);
    reset = 1'b1;
    to_negedge();
    chk("x0_never_busy", chk_busy_1, 1'b0);
    chk("midrst_alu_ready", wbif.alu_ready, 1'b0);
    next_cycle();                       // C20
    reset = 1'b0;
    idle();
    to_negedge();
    chk("midrst_dropped", din_enable, 1'b0);
    chk("midrst_count", wb_count, 32'd0);
    chk("midrst_busy", chk_busy_0, 1'b0);
    next_cycle();                       // C21: grant x6, then reset during its commit
    set(1, 5'd6, 32'h66, 0, 5'd0, '0, 0, 5'd0);
    next_cycle();                       // C22
    idle();
    reset = 1'b1;
    to_negedge();
    chk("rst_we_visible", din_enable, 1'b1);
    next_cycle();                       // C23
    reset = 1'b0;
    to_negedge();
    chk("rst_we_discarded", din_enable, 1'b0);
    chk("rst_we_count", wb_count, 32'd0);
    next_cycle();                       // C24..C26: sustained LSU
    for (int i = 0; i < 3; i++) begin
      set(0, 5'd0, '0, 1, 5'(8 + i), 32'h80 + i, 0, 5'd0);
      to_negedge();
      chk("sustain_lsu_ready", wbif.lsu_ready, 1'b1);
      next_cycle();
    end
    idle();
    next_cycle();
    next_cycle();
    to_negedge();
    chk("sustain_count", wb_count, 32'd3);
    compare_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
